// File: rtl/dot_pkg.sv
// dot_pkg: definitions shared by the dot-product unit and its accumulator.
//   - dot_acc_state_t : control states of the accumulator (IDLE/ACCUM/DONE)
//   - DOT_IN_WIDTH    : width of one dot-unit partial (the dot unit's OUTPUT_WIDTH)
//   - DOT_ACC_WIDTH   : default accumulator/result width
//   - DOT_LEN_WIDTH   : default width of the chunk-count field
package dot_pkg;

  localparam int DOT_IN_WIDTH  = 32;
  localparam int DOT_ACC_WIDTH = 48;
  localparam int DOT_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } dot_acc_state_t;

endpackage : dot_pkg

// File: rtl/dot_acc_if.sv
// dot_acc_if: job-control, partial-input and result-output signals of dot_acc.
// Signal names carry the direction as seen from dot_acc (the slave).
//   start_i/len_i            : job start and chunk count
//   in_valid_i/in_ready_o/in_data_i    : partial input handshake
//   out_valid_o/out_ready_i/out_data_o : result output handshake
//   busy_o/ovf_o             : status
// Modports: master (job issuer / partial source / result sink), slave (dot_acc).
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds valid and data stable
// until that edge, and valid never waits on ready.
interface dot_acc_if #(
  parameter int IN_WIDTH  = dot_pkg::DOT_IN_WIDTH,
  parameter int ACC_WIDTH = dot_pkg::DOT_ACC_WIDTH,
  parameter int LEN_WIDTH = dot_pkg::DOT_LEN_WIDTH
) ();

  logic                 start_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [IN_WIDTH-1:0]  in_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [ACC_WIDTH-1:0] out_data_o;
  logic                 busy_o;
  logic                 ovf_o;

  modport master (
    output start_i, len_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, busy_o, ovf_o
  );

  modport slave (
    input  start_i, len_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, busy_o, ovf_o
  );

endinterface : dot_acc_if

// File: rtl/dot_acc_add.sv
// dot_acc_add: combinational zero-extend + add with carry-out of the top
// accumulator bit.
// Configuration macro: DOT_ACC_SATURATE_EN
//   defined   : on carry-out the sum clamps to all-ones
//   undefined : the sum wraps modulo 2^ACC_WIDTH
// Ports:
//   acc_i   [ACC_WIDTH] current accumulator value
//   data_i  [IN_WIDTH]  unsigned partial, zero-extended before the add
//   sum_o   [ACC_WIDTH] next accumulator value
//   carry_o             carry out of bit ACC_WIDTH-1
module dot_acc_add #(
  parameter int IN_WIDTH  = dot_pkg::DOT_IN_WIDTH,
  parameter int ACC_WIDTH = dot_pkg::DOT_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] data_ext;
  logic [ACC_WIDTH:0] sum_ext;

  always_comb begin
    data_ext = '0;
    data_ext[IN_WIDTH-1:0] = data_i;
    sum_ext = {1'b0, acc_i} + data_ext;
    carry_o = sum_ext[ACC_WIDTH];
`ifdef DOT_ACC_SATURATE_EN
    // Once clamped, any further non-zero partial carries out again and
    // re-clamps, so the value stays at all-ones for the rest of the job.
    sum_o = carry_o ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
    sum_o = sum_ext[ACC_WIDTH-1:0];
`endif
  end

endmodule : dot_acc_add

// File: rtl/dot_acc.sv
// dot_acc: sums a programmed number of dot-unit partials into a wider
// accumulator and returns the result over a valid/ready handshake.
// Configuration macro: DOT_ACC_SATURATE_EN (saturate instead of wrap; see
// dot_acc_add).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, priority over all inputs
//   bus          dot_acc_if.slave: start/len, partial input, result output,
//                busy and sticky overflow status
//   dbg_state_o  current control state, for observation only
module dot_acc
  import dot_pkg::*;
#(
  parameter int IN_WIDTH  = DOT_IN_WIDTH,
  parameter int ACC_WIDTH = DOT_ACC_WIDTH,
  parameter int LEN_WIDTH = DOT_LEN_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  dot_acc_if.slave       bus,
  output dot_acc_state_t dbg_state_o
);

  dot_acc_state_t       state_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [ACC_WIDTH-1:0] acc_d;
  logic                 carry_d;
  logic                 beat;

  // in_ready_q is only ever high in ACCUM, so it doubles as the state gate.
  assign beat = bus.in_valid_i & in_ready_q;

  dot_acc_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .acc_i   (acc_q),
    .data_i  (bus.in_data_i),
    .sum_o   (acc_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            cnt_q  <= bus.len_i;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.len_i == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          // start_i is deliberately not looked at here.
          if (beat) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // acc_q and ovf_q are untouched here, so the result is stable
          // under back-pressure; ovf_q survives until the next start.
          if (bus.out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = acc_q;
  assign bus.busy_o      = busy_q;
  assign bus.ovf_o       = ovf_q;
  assign dbg_state_o     = state_q;

endmodule : dot_acc

// File: tb/tb_dot_acc.sv
// tb_dot_acc: directed bench for dot_acc. Two instances share one stimulus
// stream: a default 48-bit accumulator and a 33-bit one that exercises carry.
module tb_dot_acc;
  import dot_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_acc_if #(.IN_WIDTH(32), .ACC_WIDTH(48), .LEN_WIDTH(8)) b48 ();
  dot_acc_if #(.IN_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) b33 ();
  dot_acc_state_t st48, st33;

  assign b33.start_i     = b48.start_i;
  assign b33.len_i       = b48.len_i;
  assign b33.in_valid_i  = b48.in_valid_i;
  assign b33.in_data_i   = b48.in_data_i;
  assign b33.out_ready_i = b48.out_ready_i;

  dot_acc #(.IN_WIDTH(32), .ACC_WIDTH(48), .LEN_WIDTH(8)) u48 (
    .clk(clk), .rst(rst), .bus(b48.slave), .dbg_state_o(st48));
  dot_acc #(.IN_WIDTH(32), .ACC_WIDTH(33), .LEN_WIDTH(8)) u33 (
    .clk(clk), .rst(rst), .bus(b33.slave), .dbg_state_o(st33));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [47:0] exp48_q[$];
  logic        eovf48_q[$];
  logic [32:0] exp33_q[$];
  logic        eovf33_q[$];
  logic [31:0] parts[16];
  logic [47:0] last48;
  logic [32:0] last33;
  logic        lovf48, lovf33;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum of the first n partials in a w-bit register.
  function automatic logic [63:0] model_sum(input int n, input int w, output logic ovf);
    logic [63:0] acc;
    logic [63:0] lim;
    acc = 64'd0;
    lim = 64'd1 << w;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + 64'(parts[i]);
      if (acc >= lim) begin
        ovf = 1'b1;
`ifdef DOT_ACC_SATURATE_EN
        acc = lim - 64'd1;
`else
        acc = acc - lim;
`endif
      end
    end
    return acc;
  endfunction

  task automatic push_expected(input int n);
    logic [63:0] s;
    logic o;
    s = model_sum(n, 48, o);
    exp48_q.push_back(s[47:0]);
    eovf48_q.push_back(o);
    s = model_sum(n, 33, o);
    exp33_q.push_back(s[32:0]);
    eovf33_q.push_back(o);
  endtask

  // Compare process: every cycle out of reset, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (b48.out_valid_o) begin
        if (exp48_q.size() == 0) chk("unexpected_result48", 1, 0);
        else begin
          chk("data48", 64'(b48.out_data_o), 64'(exp48_q[0]));
          chk("ovf48", 64'(b48.ovf_o), 64'(eovf48_q[0]));
          if (b48.out_ready_i) begin
            void'(exp48_q.pop_front());
            void'(eovf48_q.pop_front());
          end
        end
      end
      if (b33.out_valid_o) begin
        if (exp33_q.size() == 0) chk("unexpected_result33", 1, 0);
        else begin
          chk("data33", 64'(b33.out_data_o), 64'(exp33_q[0]));
          chk("ovf33", 64'(b33.ovf_o), 64'(eovf33_q[0]));
          if (b33.out_ready_i) begin
            void'(exp33_q.pop_front());
            void'(eovf33_q.pop_front());
          end
        end
      end
      chk("rdy_vld_excl48", 64'(b48.in_ready_o & b48.out_valid_o), 0);
      chk("rdy_vld_excl33", 64'(b33.in_ready_o & b33.out_valid_o), 0);
      chk("idle_not_ready48", 64'(b48.in_ready_o & ~b48.busy_o), 0);
      chk("valid_implies_busy48", 64'(b48.out_valid_o & ~b48.busy_o), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(b48.in_ready_o), 0);
    chk({tag, "_out_valid"}, 64'(b48.out_valid_o), 0);
    chk({tag, "_out_data"}, 64'(b48.out_data_o), 0);
    chk({tag, "_busy"}, 64'(b48.busy_o), 0);
    chk({tag, "_ovf"}, 64'(b48.ovf_o), 0);
    chk({tag, "_state"}, 64'(st48), 64'(IDLE));
    chk({tag, "_out_data33"}, 64'(b33.out_data_o), 0);
    chk({tag, "_ovf33"}, 64'(b33.ovf_o), 0);
    chk({tag, "_state33"}, 64'(st33), 64'(IDLE));
  endtask

  task automatic send_beat(input logic [31:0] data, input int gap);
    logic ok;
    repeat (gap) tick();
    b48.in_valid_i = 1'b1;
    b48.in_data_i  = data;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = b48.in_ready_o;
      tick();
    end
    b48.in_valid_i = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  // Full job: start, n beats with gaps, stall cycles of back-pressure, handshake.
  task automatic run_job(input int n, input int gap, input int stall);
    push_expected(n);
    b48.out_ready_i = (stall == 0);
    b48.start_i = 1'b1;
    b48.len_i   = 8'(n);
    tick();
    b48.start_i = 1'b0;
    for (int i = 0; i < n; i++) send_beat(parts[i], gap);
    chk("latency_valid", 64'(b48.out_valid_o), 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_hold_valid", 64'(b48.out_valid_o), 1);
      tick();
    end
    b48.out_ready_i = 1'b1;
    @(negedge clk);
    chk("handshake_valid", 64'(b48.out_valid_o), 1);
    last48 = b48.out_data_o;
    lovf48 = b48.ovf_o;
    last33 = b33.out_data_o;
    lovf33 = b33.ovf_o;
    tick();
    b48.out_ready_i = 1'b0;
    chk("back_idle_busy", 64'(b48.busy_o), 0);
    chk("back_idle_valid", 64'(b48.out_valid_o), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    b48.start_i = 1'b0;
    b48.len_i = '0;
    b48.in_valid_i = 1'b0;
    b48.in_data_i = '0;
    b48.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: 1+2+3+4
    parts[0] = 1; parts[1] = 2; parts[2] = 3; parts[3] = 4;
    run_job(4, 0, 0);
    chk("t1_sum", 64'(last48), 64'd10);
    chk("t1_ovf", 64'(lovf48), 0);

    // 2: len=0 with a partial offered the whole time; never consumed
    b48.in_valid_i = 1'b1;
    b48.in_data_i  = 32'd99;
    run_job(0, 0, 0);
    chk("t2_sum", 64'(last48), 64'd0);
    b48.in_valid_i = 1'b0;

    // 3: gaps on the input, 5 cycles of back-pressure on the output
    parts[0] = 5; parts[1] = 7; parts[2] = 9;
    run_job(3, 2, 5);
    chk("t3_sum", 64'(last48), 64'd21);

    // 4: carry behaviour on the 33-bit instance
    for (int i = 0; i < 3; i++) parts[i] = 32'hFFFF_FFFF;
    run_job(2, 0, 0);
    chk("t4a_sum33", 64'(last33), 64'h1_FFFF_FFFE);
    chk("t4a_ovf33", 64'(lovf33), 0);
    run_job(3, 1, 0);
`ifdef DOT_ACC_SATURATE_EN
    chk("t4b_sum33", 64'(last33), 64'h1_FFFF_FFFF);
`else
    chk("t4b_sum33", 64'(last33), 64'h0_FFFF_FFFD);
`endif
    chk("t4b_ovf33", 64'(lovf33), 1);
    chk("t4b_sum48", 64'(last48), 64'h2_FFFF_FFFD);
    chk("t4b_ovf48", 64'(lovf48), 0);
    @(negedge clk);
    chk("t4_ovf_sticky_idle33", 64'(b33.ovf_o), 1);
    tick();

    // 5: reset after 3 of 8 beats; no result may appear for that job
    parts[0] = 11; parts[1] = 22; parts[2] = 33;
    b48.start_i = 1'b1;
    b48.len_i   = 8'd8;
    tick();
    b48.start_i = 1'b0;
    @(negedge clk);
    chk("t5_ovf_cleared_by_start33", 64'(b33.ovf_o), 0);
    chk("t5_busy", 64'(b48.busy_o), 1);
    for (int i = 0; i < 3; i++) send_beat(parts[i], 0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_vals("midjob_reset");
    tick();
    rst = 1'b0;
    parts[0] = 6; parts[1] = 6;
    run_job(2, 0, 0);
    chk("t5_sum", 64'(last48), 64'd12);
    chk("t5_sum33", 64'(last33), 64'd12);

    // 6: start during ACCUM and in the DONE handshake cycle is ignored
    parts[0] = 3; parts[1] = 4;
    push_expected(2);
    b48.start_i = 1'b1;
    b48.len_i   = 8'd2;
    tick();
    b48.start_i = 1'b0;
    send_beat(parts[0], 0);
    b48.start_i = 1'b1;
    b48.len_i   = 8'd5;
    send_beat(parts[1], 0);
    b48.start_i = 1'b0;
    chk("t6_no_reload_valid", 64'(b48.out_valid_o), 1);
    b48.out_ready_i = 1'b1;
    b48.start_i = 1'b1;
    b48.len_i   = 8'd1;
    @(negedge clk);
    chk("t6_sum", 64'(b48.out_data_o), 64'd7);
    tick();
    b48.start_i = 1'b0;
    b48.out_ready_i = 1'b0;
    chk("t6_done_start_ignored_busy", 64'(b48.busy_o), 0);
    tick();
    chk("t6_still_idle_busy", 64'(b48.busy_o), 0);
    chk("t6_still_idle_state", 64'(st48), 64'(IDLE));
    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp48_q.size() + exp33_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_dot_acc
